// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART message sequencer and its FIFOs.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } tx_state_e;

  // Ceiling log2, used for pointer and level widths at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy. DEPTH must be a power of two
// so the read/write pointers wrap naturally. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop from an empty
// FIFO is ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_LVL);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Button-to-UART message sequencer. Button presses are latched in a pending
// register, serialised lowest-index first into a TX FIFO and handed to a
// uart_tx-style send/done handshake. Received bytes are captured for display.
// Build option LOOPBACK_CHECK_EN adds an expected-byte queue and a saturating
// mismatch counter comparing received bytes against transmitted ones.
//
//   state | meaning
//   IDLE  | waiting for the TX FIFO to hold a byte
//   LOAD  | head of FIFO latched into tx_data, FIFO popped
//   SEND  | tx_send high for this single cycle
//   WAIT  | transmitter busy, waiting for tx_done
module uart_msg_sequencer
  import uart_pkg::*;
#(
  parameter int          NUM_BTN    = 4,
  parameter logic [7:0]  CHAR_BASE  = 8'h41,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ERR_W      = 8,
  localparam int         LVL_W      = clog2(FIFO_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_send,
  input  logic               tx_done,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_read,
  output logic [BYTE_W-1:0]  led,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [ERR_W-1:0]   err_cnt
);

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic [NUM_BTN-1:0] enq_clr;
  logic               enq_valid;
  logic [BYTE_W-1:0]  enq_data;

  logic               tx_full;
  logic               tx_empty;
  logic [BYTE_W-1:0]  tx_head;
  logic               tx_pop;

  tx_state_e          state_q;
  logic [BYTE_W-1:0]  tx_data_q;
  logic               tx_send_q;

  logic               rx_read_q;
  logic [BYTE_W-1:0]  led_q;
  logic               rx_fire;

  // Pick the lowest pending button while the FIFO has room; a new pulse on a
  // bit that stays pending is a lost press.
  always_comb begin
    enq_clr   = '0;
    enq_valid = 1'b0;
    enq_data  = '0;
    if (!tx_full) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (pending_q[i] && !enq_valid) begin
          enq_clr[i] = 1'b1;
          enq_valid  = 1'b1;
          enq_data   = CHAR_BASE + 8'(i);
        end
      end
    end
    pending_d  = (pending_q & ~enq_clr) | btn_pulse;
    overflow_d = overflow_q | (|(btn_pulse & pending_q & ~enq_clr));
  end

  // Pending presses and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_pop = (state_q == LOAD);

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (enq_valid),
    .pop_i   (tx_pop),
    .wdata_i (enq_data),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (fifo_level)
  );

  // Transmit sequencer with registered tx_data/tx_send.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      case (state_q)
        IDLE: if (!tx_empty) state_q <= LOAD;
        LOAD: begin
          tx_data_q <= tx_head;
          tx_send_q <= 1'b1;
          state_q   <= SEND;
        end
        SEND: state_q <= WAIT;
        WAIT: if (tx_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Back-to-back reads are blocked so uart_rx has a cycle to drop rx_valid.
  assign rx_fire = rx_valid && !rx_read_q;

  // Receive capture for the display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_read_q <= 1'b0;
      led_q     <= '0;
    end else begin
      rx_read_q <= rx_fire;
      if (rx_fire) led_q <= rx_data;
    end
  end

`ifdef LOOPBACK_CHECK_EN
  logic              exp_full;
  logic              exp_empty;
  logic [BYTE_W-1:0] exp_head;
  logic [LVL_W-1:0]  exp_level;
  logic              mismatch;
  logic [ERR_W-1:0]  err_cnt_q;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_exp_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_pop && (!exp_full || rx_fire)),
    .pop_i   (rx_fire),
    .wdata_i (tx_head),
    .rdata_o (exp_head),
    .full_o  (exp_full),
    .empty_o (exp_empty),
    .level_o (exp_level)
  );

  assign mismatch = rx_fire && (exp_empty || (rx_data != exp_head));

  // Saturating count of received bytes that do not match what was sent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (mismatch && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign rx_read  = rx_read_q;
  assign led      = led_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench for uart_msg_sequencer (8 buttons, 4-deep TX queue).
module tb_uart_msg_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] btn_pulse;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read;
  logic [7:0] led;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] sent_q[$];
  int tx_delay  = 2;
  bit hold_done = 0;
  bit rsp_quiet = 0;
  bit rsp_busy  = 0;

  uart_msg_sequencer #(
    .NUM_BTN    (8),
    .CHAR_BASE  (8'h41),
    .FIFO_DEPTH (4),
    .ERR_W      (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_pulse  (btn_pulse),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_done    (tx_done),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_read    (rx_read),
    .led        (led),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .err_cnt    (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  // uart_tx stand-in: logs each sent byte, checks tx_data holds, answers tx_done.
  initial begin
    logic [7:0] cap;
    int n;
    tx_done = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_send === 1'b1) begin
        rsp_busy = 1;
        cap = tx_data;
        sent_q.push_back(cap);
        n = 0;
        @(negedge clock);
        checks++;
        if (tx_send !== 1'b0) begin
          errors++;
          $display("FAIL tx_send_width: tx_send=%b one cycle after send, required 0", tx_send);
        end
        while (hold_done || n < tx_delay) begin
          if (!rsp_quiet) begin
            checks++;
            if (tx_data !== cap) begin
              errors++;
              $display("FAIL tx_data_stable: tx_data=%h, required %h", tx_data, cap);
            end
          end
          n++;
          @(negedge clock);
        end
        @(posedge clock); #1 tx_done = 1'b1;
        @(posedge clock); #1 tx_done = 1'b0;
        rsp_busy = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; btn_pulse = '0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic press(input logic [7:0] m);
    @(posedge clock); #1 btn_pulse = m;
    @(posedge clock); #1 btn_pulse = '0;
  endtask

  task automatic wait_sent(input int n, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (sent_q.size() >= n && !rsp_busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_rsp_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (!rsp_busy) break;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, output bit ok);
    ok = 0;
    @(posedge clock); #1 rx_data = b; rx_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (rx_read === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(posedge clock); #1 rx_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset = 1'b1; btn_pulse = '0; rx_valid = 1'b0; rx_data = '0;
    @(negedge clock);
    checks++;
    if ({tx_data, tx_send, rx_read, led, fifo_level, overflow, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tx_data=%h tx_send=%b rx_read=%b led=%h level=%0d ovf=%b err=%0d, required all 0",
               tx_data, tx_send, rx_read, led, fifo_level, overflow, err_cnt);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx_data, tx_send, rx_read, led, fifo_level, overflow, err_cnt} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: tx_send=%b level=%0d ovf=%b, required all 0", tx_send, fifo_level, overflow);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    logic [7:0] btns [2] = '{8'h02, 8'h08};
    logic [7:0] chars[2] = '{8'h42, 8'h44};
    do_reset();
    sent_q.delete();
    hold_done = 0;
    tx_delay  = 20;
    for (int p = 0; p < 2; p++) begin
      press(btns[p]);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock);
        checks++;
        if (tx_send !== (k == 4)) begin
          errors++;
          $display("FAIL latency_p%0d_c%0d: tx_send=%b, required %b", p, k, tx_send, (k == 4));
        end
        if (k == 2) begin
          checks++;
          if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL level_after_enqueue: fifo_level=%0d, required 1", fifo_level);
          end
        end
        if (k == 4) begin
          checks++;
          if (tx_data !== chars[p]) begin
            errors++;
            $display("FAIL single_tx_data: tx_data=%h, required %h", tx_data, chars[p]);
          end
        end
      end
      wait_sent(p + 1, 80, ok);
      checks++;
      if (!ok || fifo_level !== 3'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL single_done: ok=%b level=%0d ovf=%b, required 1/0/0", ok, fifo_level, overflow);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    sent_q.delete();
    tx_delay = $urandom_range(1, 5);
    press(8'h0F);
    wait_sent(4, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL simul_timeout: sent %0d bytes, required 4", sent_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sent_q[i] !== 8'(8'h41 + i)) begin
          errors++;
          $display("FAIL simul_order[%0d]: got %h, required %h", i, sent_q[i], 8'(8'h41 + i));
        end
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_overflow: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_fill();
    bit ok;
    do_reset();
    sent_q.delete();
    hold_done = 1;
    for (int b = 0; b < 6; b++) press(8'(1 << b));
    repeat (10) @(negedge clock);
    checks++;
    if (fifo_level !== 3'd4 || sent_q.size() != 1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_hold: level=%0d sent=%0d ovf=%b, required 4/1/0", fifo_level, sent_q.size(), overflow);
    end
    tx_delay  = 2;
    hold_done = 0;
    wait_sent(6, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_timeout: sent %0d bytes, required 6", sent_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (sent_q[i] !== 8'(8'h41 + i)) begin
          errors++;
          $display("FAIL fill_order[%0d]: got %h, required %h", i, sent_q[i], 8'(8'h41 + i));
        end
      end
    end
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL fill_end: ovf=%b level=%0d, required 0/0", overflow, fifo_level);
    end
  endtask

  task automatic test_collision();
    bit ok;
    int n41;
    logic [7:0] exp_seq[6] = '{8'h42, 8'h42, 8'h43, 8'h44, 8'h45, 8'h41};
    do_reset();
    sent_q.delete();
    hold_done = 1;
    press(8'h02);
    repeat (6) @(negedge clock);
    press(8'h1E);
    repeat (8) @(negedge clock);
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL coll_full: fifo_level=%0d, required 4", fifo_level);
    end
    press(8'h01);
    @(negedge clock);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL coll_first_press: overflow=%b, required 0", overflow);
    end
    press(8'h01);
    @(negedge clock);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL coll_second_press: overflow=%b, required 1", overflow);
    end
    tx_delay  = 2;
    hold_done = 0;
    wait_sent(6, 300, ok);
    repeat (30) @(negedge clock);
    n41 = 0;
    foreach (sent_q[i]) if (sent_q[i] == 8'h41) n41++;
    checks++;
    if (!ok || sent_q.size() != 6 || n41 != 1) begin
      errors++;
      $display("FAIL coll_count: sent=%0d count41=%0d, required 6/1", sent_q.size(), n41);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (sent_q[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL coll_order[%0d]: got %h, required %h", i, sent_q[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL coll_sticky: overflow=%b, required 1", overflow);
    end
  endtask

  task automatic test_rx();
    bit ok;
    logic [7:0] b;
    do_reset();
    @(posedge clock); #1 rx_data = 8'h43; rx_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (rx_read !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL rx_alternate[%0d]: rx_read=%b, required %b", k, rx_read, (k % 2 == 0));
      end
    end
    checks++;
    if (led !== 8'h43) begin
      errors++;
      $display("FAIL rx_led: led=%h, required 43", led);
    end
    @(posedge clock); #1 rx_valid = 1'b0;
    repeat (2) @(posedge clock);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_send(b, ok);
      checks++;
      if (!ok || led !== b) begin
        errors++;
        $display("FAIL rx_random[%0d]: read=%b led=%h, required 1/%h", i, ok, led, b);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] mask;
    logic [7:0] exp_q[$];
    for (int t = 0; t < 10; t++) begin
      do_reset();
      sent_q.delete();
      exp_q.delete();
      hold_done = 0;
      tx_delay  = $urandom_range(1, 6);
      mask = 8'($urandom_range(1, 255));
      for (int i = 0; i < 8; i++) if (mask[i]) exp_q.push_back(8'(8'h41 + i));
      press(mask);
      wait_sent(exp_q.size(), 500, ok);
      repeat (10) @(negedge clock);
      checks++;
      if (!ok || sent_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count[%0d]: mask=%h sent=%0d, required %0d", t, mask, sent_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (sent_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_byte[%0d.%0d]: got %h, required %h", t, i, sent_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
        errors++;
        $display("FAIL rand_end[%0d]: ovf=%b level=%0d, required 0/0", t, overflow, fifo_level);
      end
    end
  endtask

  task automatic reset_mid_wait(input string tag, input logic [7:0] btn);
    bit seen;
    int extra;
    rsp_quiet = 1;
    press(btn);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (tx_send === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_send: tx_send never seen, required a send", tag);
    end
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({tx_data, tx_send, rx_read, led, fifo_level, overflow, err_cnt} !== '0) begin
      errors++;
      $display("FAIL %s_outputs: tx_data=%h led=%h level=%0d ovf=%b err=%0d, required all 0",
               tag, tx_data, led, fifo_level, overflow, err_cnt);
    end
    @(posedge clock); #1 reset = 1'b0;
    hold_done = 0;
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (tx_send === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || fifo_level !== 3'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL %s_after: sends=%0d level=%0d tx_data=%h, required 0/0/00", tag, extra, fifo_level, tx_data);
    end
    wait_rsp_idle();
    rsp_quiet = 0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    sent_q.delete();
    tx_delay = 30;
    reset_mid_wait("rst_mid", 8'h04);
  endtask

`ifdef LOOPBACK_CHECK_EN
  task automatic test_loopback();
    bit ok;
    logic [7:0] b;
    do_reset();
    sent_q.delete();
    hold_done = 0;
    tx_delay  = 2;
    press(8'h07);
    wait_sent(3, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_sent: sent %0d bytes, required 3", sent_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      b = (i == 1) ? 8'hFF : 8'(8'h41 + i);
      rx_send(b, ok);
    end
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loop_corrupt: err_cnt=%0d, required 1", err_cnt);
    end
    rx_send(8'h55, ok);
    checks++;
    if (err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL loop_unsolicited: err_cnt=%0d, required 2", err_cnt);
    end
    hold_done = 1;
    reset_mid_wait("loop_rst", 8'h01);
  endtask
`else
  task automatic test_err_tied();
    bit ok;
    do_reset();
    rx_send(8'hA5, ok);
    rx_send(8'h5A, ok);
    checks++;
    if (err_cnt !== 8'd0 || led !== 8'h5A) begin
      errors++;
      $display("FAIL err_tied: err_cnt=%0d led=%h, required 0/5a", err_cnt, led);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; btn_pulse = '0; rx_valid = 1'b0; rx_data = '0;
    test_reset();
    test_single_press();
    wait_rsp_idle();
    test_simultaneous();
    wait_rsp_idle();
    test_fill();
    wait_rsp_idle();
    test_collision();
    wait_rsp_idle();
    test_rx();
    test_random();
    wait_rsp_idle();
    test_reset_mid_wait();
`ifdef LOOPBACK_CHECK_EN
    test_loopback();
`else
    test_err_tied();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
